// File: rtl/char_rom_arb.sv
// Round-robin arbiter sharing one single-port glyph ROM between two renderers.
// Grants one address per cycle and returns ROM data to the issuing requester after RD_LATENCY edges.
module char_rom_arb #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_e                owner_q, owner_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic [RD_LATENCY-1:0] vld_q, id_q;
  logic [RD_LATENCY:0]   vld_shift, id_shift;

  logic   owner_req;
  logic   other_req;
  logic   grant;
  owner_e gnt_owner;

  // Arbitration; requests are masked while reset is held.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_req = 1'b0;
    other_req = 1'b0;
    case (owner_q)
      OWN_0: begin
        owner_req = req0;
        other_req = req1;
      end
      OWN_1: begin
        owner_req = req1;
        other_req = req0;
      end
      default: ;
    endcase
    if (!rst) begin
      if (owner_q == OWN_NONE || !owner_req) begin
        if (req0 && req1) begin
          gnt0 = last_gnt_q;
          gnt1 = !last_gnt_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end else if (burst_cnt_q < MAX_B || !other_req) begin
        gnt0 = (owner_q == OWN_0);
        gnt1 = (owner_q == OWN_1);
      end else begin
        gnt0 = (owner_q == OWN_1);
        gnt1 = (owner_q == OWN_0);
      end
    end
  end

  assign grant     = gnt0 | gnt1;
  assign gnt_owner = gnt1 ? OWN_1 : OWN_0;

  always_comb begin
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    if (grant) begin
      if (owner_q != gnt_owner) begin
        owner_d     = gnt_owner;
        last_gnt_d  = gnt1;
        burst_cnt_d = 8'd1;
      end else if (burst_cnt_q < MAX_B) begin
        burst_cnt_d = burst_cnt_q + 8'd1;
      end
    end else begin
      owner_d     = OWN_NONE;
      burst_cnt_d = 8'd0;
    end
  end

  // Stage 0 sits at bit 0; the concatenation drops the oldest stage on each shift.
  assign vld_shift = {vld_q, grant};
  assign id_shift  = {id_q, gnt1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= 8'd0;
      vld_q       <= '0;
      id_q        <= '0;
    end else begin
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      vld_q       <= vld_shift[RD_LATENCY-1:0];
      id_q        <= id_shift[RD_LATENCY-1:0];
    end
  end

  assign rvalid0  = vld_q[RD_LATENCY-1] & ~id_q[RD_LATENCY-1];
  assign rvalid1  = vld_q[RD_LATENCY-1] &  id_q[RD_LATENCY-1];
  assign rdata0   = rom_rd_data;
  assign rdata1   = rom_rd_data;
  assign rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

endmodule

// File: tb/tb_char_rom_arb.sv
// Directed bench for char_rom_arb: three instances cover latency 1/2 and burst limits 1/2/16.
module tb_char_rom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [9:0]  addr0 = 10'h041, addr1 = 10'h123;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [9:0] a);
    if (a == 10'h041) return 32'hA5A5A5A5;
    return {8'hC0, 14'h0, a};
  endfunction

  // a: RD_LATENCY=1 MAX_BURST=2, b: RD_LATENCY=1 MAX_BURST=16, c: RD_LATENCY=2 MAX_BURST=1
  logic        gnt0_a, gnt1_a, rv0_a, rv1_a;
  logic        gnt0_b, gnt1_b, rv0_b, rv1_b;
  logic        gnt0_c, gnt1_c, rv0_c, rv1_c;
  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c;
  logic [9:0]  ra_a, ra_b, ra_c;
  logic [31:0] rom_a, rom_b, rom_c, rom_c1;

  always @(posedge clk) begin
    rom_a  <= rom_f(ra_a);
    rom_b  <= rom_f(ra_b);
    rom_c1 <= rom_f(ra_c);
    rom_c  <= rom_c1;
  end

  char_rom_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1), .MAX_BURST(2)) u_a (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rv0_a), .rdata0(rd0_a),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rvalid1(rv1_a), .rdata1(rd1_a),
    .rom_addr(ra_a), .rom_rd_data(rom_a)
  );

  char_rom_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1), .MAX_BURST(16)) u_b (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rv0_b), .rdata0(rd0_b),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rvalid1(rv1_b), .rdata1(rd1_b),
    .rom_addr(ra_b), .rom_rd_data(rom_b)
  );

  char_rom_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(2), .MAX_BURST(1)) u_c (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_c), .rvalid0(rv0_c), .rdata0(rd0_c),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_c), .rvalid1(rv1_c), .rdata1(rd1_c),
    .rom_addr(ra_c), .rom_rd_data(rom_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_a, gnt1_a, rv0_a, rv1_a, gnt0_b, gnt1_b, rv0_b, rv1_b, gnt0_c, gnt1_c, rv0_c, rv1_c} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_ctrl: got a=%b%b%b%b b=%b%b%b%b c=%b%b%b%b want all 0", gnt0_a, gnt1_a, rv0_a, rv1_a,
               gnt0_b, gnt1_b, rv0_b, rv1_b, gnt0_c, gnt1_c, rv0_c, rv1_c);
    end
    n_cmp++;
    if ({ra_a, ra_b, ra_c} !== 30'h0) begin
      n_err++;
      $display("FAIL reset_rom_addr: got %h %h %h want 0", ra_a, ra_b, ra_c);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    req0  = 1'b1;
    addr0 = 10'h041;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_a, gnt1_a, rv0_a, rv1_a} !== 4'b1000 || ra_a !== 10'h041) begin
      n_err++;
      $display("FAIL single_grant: got g=%b%b rv=%b%b addr=%h want g=10 rv=00 addr=041", gnt0_a, gnt1_a, rv0_a, rv1_a, ra_a);
    end
    step();
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_a, gnt1_a, rv0_a, rv1_a} !== 4'b0010 || ra_a !== 10'h000) begin
      n_err++;
      $display("FAIL single_rvalid: got g=%b%b rv=%b%b addr=%h want g=00 rv=10 addr=000", gnt0_a, gnt1_a, rv0_a, rv1_a, ra_a);
    end
    n_cmp++;
    if (rd0_a !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL single_rdata: got %h want a5a5a5a5", rd0_a);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({rv0_a, rv1_a} !== 2'b00) begin
      n_err++;
      $display("FAIL single_one_pulse: got rv=%b%b want 00", rv0_a, rv1_a);
    end
    step();
  endtask

  task automatic test_contention();
    logic seq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp;
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      exp[3] = (k < 4) && !seq[k];
      exp[2] = (k < 4) &&  seq[k];
      exp[1] = (k > 0) && !seq[k-1];
      exp[0] = (k > 0) &&  seq[k-1];
      @(negedge clk);
      n_cmp++;
      if ({gnt0_a, gnt1_a, rv0_a, rv1_a} !== exp) begin
        n_err++;
        $display("FAIL contention_c%0d: got g/rv=%b%b%b%b want %b", k, gnt0_a, gnt1_a, rv0_a, rv1_a, exp);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req0  = 1'b1;
    addr0 = 10'h041;
    addr1 = 10'h123;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt0_b, gnt1_b, rv0_b} !== {2'b10, k > 0}) begin
        n_err++;
        $display("FAIL saturate_c%0d: got g=%b%b rv0=%b want g=10 rv0=%b", k, gnt0_b, gnt1_b, rv0_b, k > 0);
      end
      step();
    end
    req1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_b, gnt1_b} !== 2'b01 || ra_b !== 10'h123) begin
      n_err++;
      $display("FAIL saturate_switch: got g=%b%b addr=%h want g=01 addr=123", gnt0_b, gnt1_b, ra_b);
    end
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rv0_b, rv1_b} !== 2'b01 || rd1_b !== 32'hC0000123) begin
      n_err++;
      $display("FAIL saturate_return: got rv=%b%b data=%h want rv=01 data=c0000123", rv0_b, rv1_b, rd1_b);
    end
    step();
  endtask

  task automatic test_latency2();
    logic [1:0]  rq  [6] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [9:0]  a0  [6] = '{10'h041, 10'h041, 10'h2A0, 10'h2A0, 10'h2A0, 10'h2A0};
    logic [1:0]  erv [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [31:0] edt [6] = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'hC0000123, 32'hC00002A0, 32'h0};
    do_reset();
    addr1 = 10'h123;
    for (int k = 0; k < 6; k++) begin
      {req0, req1} = rq[k];
      addr0 = a0[k];
      @(negedge clk);
      n_cmp++;
      if ({gnt0_c, gnt1_c, rv0_c, rv1_c} !== {rq[k], erv[k]}) begin
        n_err++;
        $display("FAIL lat2_c%0d: got g/rv=%b%b%b%b want %b%b", k, gnt0_c, gnt1_c, rv0_c, rv1_c, rq[k], erv[k]);
      end
      if (erv[k] != 2'b00) begin
        n_cmp++;
        if ((erv[k][1] ? rd0_c : rd1_c) !== edt[k]) begin
          n_err++;
          $display("FAIL lat2_data_c%0d: got %h want %h", k, erv[k][1] ? rd0_c : rd1_c, edt[k]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req0  = 1'b1;
    addr0 = 10'h041;
    addr1 = 10'h123;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_c, gnt1_c} !== 2'b10) begin
      n_err++;
      $display("FAIL midrst_grant: got g=%b%b want 10", gnt0_c, gnt1_c);
    end
    step();
    req0 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_c, gnt1_c, rv0_c, rv1_c} !== 4'b0000 || ra_c !== 10'h000) begin
      n_err++;
      $display("FAIL midrst_outputs: got g/rv=%b%b%b%b addr=%h want 0000 addr=000", gnt0_c, gnt1_c, rv0_c, rv1_c, ra_c);
    end
    step();
    rst  = 1'b0;
    req1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_c, gnt1_c, rv0_c, rv1_c} !== 4'b0100 || ra_c !== 10'h123) begin
      n_err++;
      $display("FAIL midrst_discard: got g/rv=%b%b%b%b addr=%h want 0100 addr=123", gnt0_c, gnt1_c, rv0_c, rv1_c, ra_c);
    end
    step();
    req1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rv0_c, rv1_c} !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_gap: got rv=%b%b want 00", rv0_c, rv1_c);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({rv0_c, rv1_c} !== 2'b01 || rd1_c !== 32'hC0000123) begin
      n_err++;
      $display("FAIL midrst_return: got rv=%b%b data=%h want rv=01 data=c0000123", rv0_c, rv1_c, rd1_c);
    end
    step();
  endtask

  task automatic test_handover();
    logic [1:0] rq [6] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [1:0] gc [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0] gb [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      {req0, req1} = rq[k];
      @(negedge clk);
      n_cmp++;
      if ({gnt0_c, gnt1_c} !== gc[k]) begin
        n_err++;
        $display("FAIL handover_mb1_c%0d: got g=%b%b want %b", k, gnt0_c, gnt1_c, gc[k]);
      end
      n_cmp++;
      if ({gnt0_b, gnt1_b} !== gb[k]) begin
        n_err++;
        $display("FAIL handover_mb16_c%0d: got g=%b%b want %b", k, gnt0_b, gnt1_b, gb[k]);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_saturation();
    test_latency2();
    test_reset_midflight();
    test_handover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
